// File: rtl/text_pkg.sv
// Shared text-overlay definitions: entry FSM states, HID keycodes
// and ASCII constants reused by the overlay text blocks.
package text_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        ENTRY = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_Z     = 8'h1D;
    localparam logic [7:0] KC_1     = 8'h1E;
    localparam logic [7:0] KC_0     = 8'h27;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_BKSP  = 8'h2A;
    localparam logic [7:0] KC_SPACE = 8'h2C;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_A     = 7'h41;
    localparam logic [6:0] ASCII_1     = 7'h31;
    localparam logic [6:0] ASCII_0     = 7'h30;

    typedef struct packed {
        logic       printable;
        logic       is_bksp;
        logic       is_enter;
        logic [6:0] ascii;
    } hid_dec_t;

endpackage

// File: rtl/hid_to_ascii.sv
// Combinational HID keycode classifier and ASCII translator
// for letters, digits, space, backspace and enter.
module hid_to_ascii
    import text_pkg::*;
(
    input  logic [7:0] keycode,
    output hid_dec_t   dec
);

    logic [7:0] w_alpha;
    logic [7:0] w_digit;
    logic       w_is_alpha;
    logic       w_is_digit;

    // Offsets fold the keycode base into the ASCII base
    assign w_alpha = keycode - KC_A + {1'b0, ASCII_A};
    assign w_digit = keycode - KC_1 + {1'b0, ASCII_1};

    assign w_is_alpha = (keycode >= KC_A) && (keycode <= KC_Z);
    assign w_is_digit = (keycode >= KC_1) && (keycode < KC_0);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            w_is_alpha: begin
                dec.printable = 1'b1;
                dec.ascii     = w_alpha[6:0];
            end
            w_is_digit: begin
                dec.printable = 1'b1;
                dec.ascii     = w_digit[6:0];
            end
            (keycode == KC_0): begin
                dec.printable = 1'b1;
                dec.ascii     = ASCII_0;
            end
            (keycode == KC_SPACE): begin
                dec.printable = 1'b1;
                dec.ascii     = ASCII_SPACE;
            end
            (keycode == KC_BKSP): begin
                dec.is_bksp = 1'b1;
            end
            (keycode == KC_ENTER): begin
                dec.is_enter = 1'b1;
            end
            default: begin
                dec = '0;
            end
        endcase
    end

endmodule

// File: rtl/team_name_entry_ctrl.sv
// Team-name entry sequencer: turns key events into slot writes for
// the overlay name register and blank-fills it on reset or request.
module team_name_entry_ctrl
    import text_pkg::*;
#(
    parameter int         NAME_LEN = 7,
    parameter int         ADDR_W   = 3,
    parameter logic [6:0] PAD_CHAR = 7'h20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    input  logic              entry_enable,
    input  logic              clear_req,
    output logic [6:0]        team_in,
    output logic [ADDR_W-1:0] team_addr,
    output logic              we,
    output logic [ADDR_W-1:0] name_len,
    output logic              name_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LP_MAX  = ADDR_W'(NAME_LEN);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NAME_LEN - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [7:0]        r_key_prev;
    logic              w_key_ev;
    hid_dec_t          w_dec;
    logic [ADDR_W-1:0] r_clr;
    logic [ADDR_W-1:0] w_clr_nx;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] w_len_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [6:0]        r_data;
    logic [6:0]        w_data_nx;
    logic              r_we;
    logic              w_we_nx;
    logic              r_done;
    logic              r_busy;

    hid_to_ascii u_dec (
        .keycode (keycode),
        .dec     (w_dec)
    );

    // A held key yields one event; a direct change to another key yields another
    assign w_key_ev = (keycode != 8'h00) && (keycode != r_key_prev);

    always_comb begin
        w_state_nx = r_state;
        w_clr_nx   = r_clr;
        w_len_nx   = r_len;
        w_we_nx    = 1'b0;
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        unique case (r_state)
            CLEAR: begin
                w_we_nx   = 1'b1;
                w_addr_nx = r_clr;
                w_data_nx = PAD_CHAR;
                w_clr_nx  = r_clr + 1'b1;
                if (r_clr == LP_LAST) begin
                    w_state_nx = IDLE;
                    w_clr_nx   = '0;
                    w_len_nx   = '0;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    w_state_nx = CLEAR;
                    w_clr_nx   = '0;
                end else if (entry_enable) begin
                    w_state_nx = ENTRY;
                end
            end
            ENTRY: begin
                if (clear_req) begin
                    w_state_nx = CLEAR;
                    w_clr_nx   = '0;
                end else if (!entry_enable) begin
                    w_state_nx = IDLE;
                end else if (w_key_ev) begin
                    unique case (1'b1)
                        w_dec.printable: begin
                            if (r_len < LP_MAX) begin
                                w_we_nx   = 1'b1;
                                w_addr_nx = r_len;
                                w_data_nx = w_dec.ascii;
                                w_len_nx  = r_len + 1'b1;
                            end
                        end
                        w_dec.is_bksp: begin
                            if (r_len != '0) begin
                                w_we_nx   = 1'b1;
                                w_addr_nx = r_len - 1'b1;
                                w_data_nx = PAD_CHAR;
                                w_len_nx  = r_len - 1'b1;
                            end
                        end
                        w_dec.is_enter: begin
                            if (r_len != '0) begin
                                w_state_nx = DONE;
                            end
                        end
                        default: begin
                            w_we_nx = 1'b0;
                        end
                    endcase
                end
            end
            DONE: begin
                if (clear_req) begin
                    w_state_nx = CLEAR;
                    w_clr_nx   = '0;
                end
            end
            default: begin
                w_state_nx = CLEAR;
                w_clr_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= CLEAR;
            r_clr      <= '0;
            r_len      <= '0;
            r_key_prev <= 8'h00;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= PAD_CHAR;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_clr      <= w_clr_nx;
            r_len      <= w_len_nx;
            r_key_prev <= keycode;
            r_we       <= w_we_nx;
            r_addr     <= w_addr_nx;
            r_data     <= w_data_nx;
            r_done     <= (w_state_nx == DONE);
            r_busy     <= (r_state == CLEAR) || (w_state_nx == CLEAR);
        end
    end

    assign team_in   = r_data;
    assign team_addr = r_addr;
    assign we        = r_we;
    assign name_len  = r_len;
    assign name_done = r_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_team_name_entry_ctrl.sv
// Directed bench for team_name_entry_ctrl: sweep, typing, backspace,
// enter and clear with hand-computed expected writes.
module tb_team_name_entry_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] keycode;
    logic       entry_enable;
    logic       clear_req;
    logic [6:0] team_in;
    logic [2:0] team_addr;
    logic       we;
    logic [2:0] name_len;
    logic       name_done;
    logic       busy;

    int n_chk;
    int n_fail;
    int wr_cnt;
    int wr_addr;
    int wr_data;

    team_name_entry_ctrl dut (
        .Clk          (clk),
        .Reset        (rst),
        .keycode      (keycode),
        .entry_enable (entry_enable),
        .clear_req    (clear_req),
        .team_in      (team_in),
        .team_addr    (team_addr),
        .we           (we),
        .name_len     (name_len),
        .name_done    (name_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (we) begin
            wr_cnt++;
            wr_addr = int'(team_addr);
            wr_data = int'(team_in);
        end
    endtask

    task automatic press(input logic [7:0] kc, input int hold);
        wr_cnt  = 0;
        wr_addr = -1;
        wr_data = -1;
        keycode = kc;
        repeat (hold) tick();
        keycode = 8'h00;
        tick();
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk({tag, "_we"}, int'(we), 1);
            chk({tag, "_addr"}, int'(team_addr), i);
            chk({tag, "_data"}, int'(team_in), 'h20);
            chk({tag, "_busy"}, int'(busy), 1);
        end
        chk({tag, "_len"}, int'(name_len), 0);
        tick();
        chk({tag, "_busy_end"}, int'(busy), 0);
        chk({tag, "_we_end"}, int'(we), 0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        wr_cnt = 0;
        wr_addr = -1;
        wr_data = -1;
        rst = 1'b1;
        keycode = 8'h00;
        entry_enable = 1'b0;
        clear_req = 1'b0;

        // 1: reset then power-on sweep
        tick();
        tick();
        chk("rst_we", int'(we), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_len", int'(name_len), 0);
        chk("rst_done", int'(name_done), 0);
        chk("rst_data", int'(team_in), 'h20);
        chk("rst_addr", int'(team_addr), 0);
        rst = 1'b0;
        sweep("init");

        // 2: held key writes once
        entry_enable = 1'b1;
        tick();
        press(8'h04, 10);
        chk("hold_wr", wr_cnt, 1);
        chk("hold_addr", wr_addr, 0);
        chk("hold_data", wr_data, 'h41);
        chk("hold_len", int'(name_len), 1);

        // 3: fill all slots, eighth key rejected
        press(8'h2A, 1);
        chk("bs0_addr", wr_addr, 0);
        chk("bs0_len", int'(name_len), 0);
        for (int k = 0; k < 8; k++) begin
            press(8'h05 + 8'(k), 1);
            if (k < 7) begin
                chk("fill_wr", wr_cnt, 1);
                chk("fill_addr", wr_addr, k);
                chk("fill_data", wr_data, 'h42 + k);
            end else begin
                chk("full_wr", wr_cnt, 0);
            end
        end
        chk("full_len", int'(name_len), 7);

        // 4: backspace
        repeat (4) press(8'h2A, 1);
        chk("bs_len3", int'(name_len), 3);
        press(8'h2A, 1);
        chk("bs_wr", wr_cnt, 1);
        chk("bs_addr", wr_addr, 2);
        chk("bs_data", wr_data, 'h20);
        chk("bs_len2", int'(name_len), 2);
        repeat (2) press(8'h2A, 1);
        press(8'h2A, 1);
        chk("bs_empty_wr", wr_cnt, 0);
        chk("bs_empty_len", int'(name_len), 0);

        // digits and space decode
        press(8'h27, 1);
        chk("dig0_data", wr_data, 'h30);
        press(8'h26, 1);
        chk("dig9_data", wr_data, 'h39);
        press(8'h2C, 1);
        chk("space_data", wr_data, 'h20);
        chk("space_addr", wr_addr, 2);
        press(8'h2D, 1);
        chk("unmapped_wr", wr_cnt, 0);
        repeat (3) press(8'h2A, 1);
        chk("bs3_len", int'(name_len), 0);

        // 5: enter
        press(8'h28, 1);
        chk("ent_empty_done", int'(name_done), 0);
        chk("ent_empty_wr", wr_cnt, 0);
        press(8'h04, 1);
        press(8'h05, 1);
        chk("ent_len", int'(name_len), 2);
        wr_cnt = 0;
        keycode = 8'h28;
        tick();
        chk("ent_done", int'(name_done), 1);
        keycode = 8'h00;
        tick();
        press(8'h06, 1);
        chk("done_wr", wr_cnt, 0);
        chk("done_hold", int'(name_done), 1);
        chk("done_len", int'(name_len), 2);

        // 6: clear from DONE, then clear racing a key in ENTRY
        clear_req = 1'b1;
        keycode = 8'h04;
        tick();
        clear_req = 1'b0;
        keycode = 8'h00;
        chk("clr_done_we", int'(we), 0);
        chk("clr_done_flag", int'(name_done), 0);
        sweep("clr1");
        press(8'h07, 1);
        chk("post_clr_addr", wr_addr, 0);
        chk("post_clr_len", int'(name_len), 1);
        clear_req = 1'b1;
        keycode = 8'h04;
        tick();
        clear_req = 1'b0;
        keycode = 8'h00;
        chk("clr_race_we", int'(we), 0);
        sweep("clr2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
